tlc_multiphase_ctrl: RTL and testbench

//  Parametrised N-approach traffic-light controller; successor to the 2-road TLC FSM.

---
 rtl/tlc_pkg.sv | 31 +++
 rtl/tlc_phase_timer.sv | 45 ++++
 rtl/tlc_multiphase_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_tlc_multiphase_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// -----------------------------------------------------------------------------
// tlc_pkg
// Shared definitions for the multiphase traffic-light controller:
//   - lamp colour codes (2 bits per approach)
//   - controller state enumeration
//   - phase_next(): round-robin successor of a phase index
// No ports (package).
// -----------------------------------------------------------------------------
package tlc_pkg;

    // Lamp codes as driven on each 2-bit slice of the lights bus
    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] GRN = 2'b10;

    // Controller states; EMG_* are the emergency preemption states
    typedef enum logic [2:0] {
        GREEN     = 3'd0,
        YELLOW    = 3'd1,
        ALLRED    = 3'd2,
        PED_WALK  = 3'd3,
        EMG_CLEAR = 3'd4,
        EMG_HOLD  = 3'd5
    } state_e;

    // Next phase in round-robin order, wrapping from n-1 back to 0
    function automatic int unsigned phase_next(input int unsigned p, input int unsigned n);
        return ((p + 32'd1) >= n) ? 32'd0 : (p + 32'd1);
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// -----------------------------------------------------------------------------
// tlc_phase_timer
// Loadable down-counter used as the per-state dwell timer.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset (counter returns to RST_VAL)
//   load_i  in   load val_i this cycle (wins over hold/decrement)
//   val_i   in   value to load
//   hold_i  in   freeze the count
//   cnt_o   out  current count (cycles remaining in the current state)
//   last_o  out  high when the count is 1, i.e. final cycle of the state
// -----------------------------------------------------------------------------
module tlc_phase_timer #(
    parameter int               CNT_W   = 4,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] val_i,
    input  logic             hold_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;

    // Count register: load has priority, otherwise hold or count down.
    // The count saturates at zero so an unattended timer never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (hold_i || (cnt_q == '0)) begin
            cnt_q <= cnt_q;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/tlc_multiphase_ctrl.sv
// -----------------------------------------------------------------------------
// tlc_multiphase_ctrl
// N-approach traffic-light controller. Serves phases round-robin through
// green -> yellow -> all-red, inserts a pedestrian walk interval after the
// all-red when a request is latched, and preempts to a selectable phase on
// emergency (through a clearance interval unless that phase is already green).
// Ports:
//   clk              in   rising-edge clock
//   rst              in   asynchronous active-high reset
//   ped_req_i        in   pedestrian request pulse (latched)
//   emergency_i      in   emergency level, high for the whole emergency
//   emg_phase_i      in   phase to turn green during the emergency
//   lights_o         out  2 bits per phase: RED=00 YEL=01 GRN=10
//   cur_phase_o      out  phase currently served
//   ped_walk_o       out  walk lamp
//   ped_pending_o    out  latched, not yet served pedestrian request
//   emg_active_o     out  high during emergency clearance or hold
//   timer_display_o  out  cycles remaining in current state (0 while holding)
// -----------------------------------------------------------------------------
module tlc_multiphase_ctrl
    import tlc_pkg::*;
#(
    parameter int N_PHASES  = 4,
    parameter int CNT_W     = 4,
    parameter int T_GREEN   = 5,
    parameter int T_YELLOW  = 2,
    parameter int T_ALLRED  = 1,
    parameter int T_PED     = 4,
    parameter int T_EMG_CLR = 2,
    localparam int PW       = $clog2(N_PHASES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ped_req_i,
    input  logic                  emergency_i,
    input  logic [PW-1:0]         emg_phase_i,
    output logic [2*N_PHASES-1:0] lights_o,
    output logic [PW-1:0]         cur_phase_o,
    output logic                  ped_walk_o,
    output logic                  ped_pending_o,
    output logic                  emg_active_o,
    output logic [CNT_W-1:0]      timer_display_o
);

    localparam int T_MAX = (2 ** CNT_W) - 1;

    // Reject parameter sets the timer width or phase encoding cannot support
    if (N_PHASES < 2 || N_PHASES > 8) begin : g_bad_phases
        $error("tlc_multiphase_ctrl: N_PHASES must be within 2..8");
    end
    if (T_GREEN < 1 || T_GREEN > T_MAX || T_YELLOW < 1 || T_YELLOW > T_MAX ||
        T_ALLRED < 1 || T_ALLRED > T_MAX || T_PED < 1 || T_PED > T_MAX ||
        T_EMG_CLR < 1 || T_EMG_CLR > T_MAX) begin : g_bad_times
        $error("tlc_multiphase_ctrl: every T_* must be within 1..2**CNT_W-1");
    end

    localparam logic [2*N_PHASES-1:0] LIGHTS_RST = {{(2*N_PHASES-2){1'b0}}, GRN};

    state_e                  state_q, state_d;
    logic [PW-1:0]           phase_q, phase_d;
    logic [PW-1:0]           emg_q, emg_d;
    logic                    clr_yel_q, clr_yel_d;
    logic                    ped_pending_q, ped_pending_d;
    logic [2*N_PHASES-1:0]   lights_q, lights_d;
    logic                    walk_q, walk_d;
    logic                    emg_act_q, emg_act_d;

    logic [PW-1:0]           emg_sel;
    logic [PW-1:0]           phase_succ;
    logic                    t_load, t_hold, t_last;
    logic [CNT_W-1:0]        t_val, t_cnt;

    // Out-of-range emergency targets fall back to phase 0
    assign emg_sel    = (32'(emg_phase_i) >= N_PHASES) ? '0 : emg_phase_i;
    assign phase_succ = PW'(phase_next(32'(phase_q), N_PHASES));

    tlc_phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(T_GREEN))
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (t_load),
        .val_i  (t_val),
        .hold_i (t_hold),
        .cnt_o  (t_cnt),
        .last_o (t_last)
    );

    // Next-state logic. Emergency is looked at first in every non-emergency
    // state; otherwise a state is left on its final timer cycle and the timer
    // is reloaded with the dwell of the state being entered. While in
    // EMG_CLEAR the phase register still holds the interrupted phase, which is
    // what the no-hold exit uses to pick the following green.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        emg_d         = emg_q;
        clr_yel_d     = clr_yel_q;
        ped_pending_d = ped_pending_q | ped_req_i;
        t_load        = 1'b0;
        t_val         = '0;
        t_hold        = 1'b0;

        case (state_q)
            GREEN, YELLOW, ALLRED, PED_WALK: begin
                if (emergency_i) begin
                    emg_d = emg_sel;
                    if (state_q == GREEN && phase_q == emg_sel) begin
                        state_d = EMG_HOLD;
                        t_load  = 1'b1;
                        t_val   = '0;
                    end else begin
                        state_d   = EMG_CLEAR;
                        t_load    = 1'b1;
                        t_val     = CNT_W'(T_EMG_CLR);
                        clr_yel_d = (state_q == GREEN);
                        // An aborted walk has to be served again later
                        if (state_q == PED_WALK) begin
                            ped_pending_d = 1'b1;
                        end
                    end
                end else if (t_last) begin
                    t_load = 1'b1;
                    case (state_q)
                        GREEN: begin
                            state_d = YELLOW;
                            t_val   = CNT_W'(T_YELLOW);
                        end
                        YELLOW: begin
                            state_d = ALLRED;
                            t_val   = CNT_W'(T_ALLRED);
                        end
                        ALLRED: begin
                            if (ped_pending_q) begin
                                state_d       = PED_WALK;
                                t_val         = CNT_W'(T_PED);
                                // This walk also covers a request arriving now
                                ped_pending_d = 1'b0;
                            end else begin
                                state_d = GREEN;
                                phase_d = phase_succ;
                                t_val   = CNT_W'(T_GREEN);
                            end
                        end
                        default: begin
                            state_d = GREEN;
                            phase_d = phase_succ;
                            t_val   = CNT_W'(T_GREEN);
                        end
                    endcase
                end
            end

            EMG_CLEAR: begin
                if (t_last) begin
                    t_load    = 1'b1;
                    clr_yel_d = 1'b0;
                    if (emergency_i) begin
                        state_d = EMG_HOLD;
                        phase_d = emg_q;
                        t_val   = '0;
                    end else begin
                        state_d = GREEN;
                        phase_d = phase_succ;
                        t_val   = CNT_W'(T_GREEN);
                    end
                end
            end

            EMG_HOLD: begin
                t_hold = 1'b1;
                if (!emergency_i) begin
                    state_d = YELLOW;
                    t_hold  = 1'b0;
                    t_load  = 1'b1;
                    t_val   = CNT_W'(T_YELLOW);
                end
            end

            default: begin
                state_d = GREEN;
                phase_d = '0;
                t_load  = 1'b1;
                t_val   = CNT_W'(T_GREEN);
            end
        endcase
    end

    // Lamp and indicator decode from the upcoming state so that the output
    // registers line up with the state register.
    always_comb begin
        lights_d  = {N_PHASES{RED}};
        walk_d    = (state_d == PED_WALK);
        emg_act_d = (state_d == EMG_CLEAR) || (state_d == EMG_HOLD);
        for (int p = 0; p < N_PHASES; p++) begin
            if (PW'(p) == phase_d) begin
                case (state_d)
                    GREEN, EMG_HOLD: lights_d[2*p +: 2] = GRN;
                    YELLOW:          lights_d[2*p +: 2] = YEL;
                    EMG_CLEAR: begin
                        if (clr_yel_d) begin
                            lights_d[2*p +: 2] = YEL;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Controller state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= GREEN;
            phase_q       <= '0;
            emg_q         <= '0;
            clr_yel_q     <= 1'b0;
            ped_pending_q <= 1'b0;
            lights_q      <= LIGHTS_RST;
            walk_q        <= 1'b0;
            emg_act_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            emg_q         <= emg_d;
            clr_yel_q     <= clr_yel_d;
            ped_pending_q <= ped_pending_d;
            lights_q      <= lights_d;
            walk_q        <= walk_d;
            emg_act_q     <= emg_act_d;
        end
    end

    assign lights_o        = lights_q;
    assign cur_phase_o     = phase_q;
    assign ped_walk_o      = walk_q;
    assign ped_pending_o   = ped_pending_q;
    assign emg_active_o    = emg_act_q;
    assign timer_display_o = t_cnt;

endmodule

// File: tb/tb_tlc_multiphase_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tlc_multiphase_ctrl
// Scoreboard bench for tlc_multiphase_ctrl. Stimulus is driven at the falling
// edge; a reference model computes what the outputs must look like after the
// following rising edge and queues it. A monitor pops one entry per cycle,
// just after the rising edge, and compares. Reset assertion is also checked
// directly, before any clock edge, to cover its asynchronous effect.
// -----------------------------------------------------------------------------
module tb_tlc_multiphase_ctrl;

    localparam int N         = 4;
    localparam int CNT_W     = 4;
    localparam int T_GREEN   = 5;
    localparam int T_YELLOW  = 2;
    localparam int T_ALLRED  = 1;
    localparam int T_PED     = 4;
    localparam int T_EMG_CLR = 2;
    localparam int PW        = 2;

    // Reference model segment kinds
    localparam int K_GO    = 0;
    localparam int K_AMBER = 1;
    localparam int K_CLEAR = 2;
    localparam int K_WALK  = 3;
    localparam int K_PRE   = 4;
    localparam int K_HOLD  = 5;

    typedef struct packed {
        logic [2*N-1:0]   lights;
        logic [PW-1:0]    phase;
        logic             walk;
        logic             pending;
        logic             emgAct;
        logic [CNT_W-1:0] display;
    } expT;

    logic             clk = 1'b0;
    logic             rst;
    logic             pedReq;
    logic             emergency;
    logic [PW-1:0]    emgPhase;
    logic [2*N-1:0]   lights;
    logic [PW-1:0]    curPhase;
    logic             pedWalk;
    logic             pedPending;
    logic             emgActive;
    logic [CNT_W-1:0] timerDisplay;

    expT sbQ[$];
    int  checkCount = 0;
    int  errorCount = 0;
    int  cycle      = 0;

    int  mKind, mLeft, mPhase, mEmg;
    bit  mPending, mAmber;

    tlc_multiphase_ctrl #(
        .N_PHASES  (N),
        .CNT_W     (CNT_W),
        .T_GREEN   (T_GREEN),
        .T_YELLOW  (T_YELLOW),
        .T_ALLRED  (T_ALLRED),
        .T_PED     (T_PED),
        .T_EMG_CLR (T_EMG_CLR)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ped_req_i       (pedReq),
        .emergency_i     (emergency),
        .emg_phase_i     (emgPhase),
        .lights_o        (lights),
        .cur_phase_o     (curPhase),
        .ped_walk_o      (pedWalk),
        .ped_pending_o   (pedPending),
        .emg_active_o    (emgActive),
        .timer_display_o (timerDisplay)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Reference model: the junction is a sequence of timed segments; when a
    // segment runs out the next one is chosen from the rules of the junction.
    function automatic void modelReset();
        mKind    = K_GO;
        mLeft    = T_GREEN;
        mPhase   = 0;
        mEmg     = 0;
        mPending = 1'b0;
        mAmber   = 1'b0;
    endfunction

    function automatic void startGreenAfter(input int p);
        mKind  = K_GO;
        mLeft  = T_GREEN;
        mPhase = (p + 1) % N;
    endfunction

    function automatic void modelStep(input bit r, input bit p, input bit e, input int ph);
        bit newPending;
        if (r) begin
            modelReset();
            return;
        end
        newPending = mPending | p;
        if (e && mKind != K_PRE && mKind != K_HOLD) begin
            mEmg = (ph < N) ? ph : 0;
            if (mKind == K_GO && mPhase == mEmg) begin
                mKind = K_HOLD;
                mLeft = 0;
            end else begin
                if (mKind == K_WALK) newPending = 1'b1;
                mAmber = (mKind == K_GO);
                mKind  = K_PRE;
                mLeft  = T_EMG_CLR;
            end
        end else if (mKind == K_HOLD) begin
            if (!e) begin
                mKind = K_AMBER;
                mLeft = T_YELLOW;
            end
        end else if (mLeft > 1) begin
            mLeft--;
        end else begin
            case (mKind)
                K_GO:    begin mKind = K_AMBER; mLeft = T_YELLOW; end
                K_AMBER: begin mKind = K_CLEAR; mLeft = T_ALLRED; end
                K_CLEAR: begin
                    if (mPending) begin
                        mKind      = K_WALK;
                        mLeft      = T_PED;
                        newPending = 1'b0;
                    end else begin
                        startGreenAfter(mPhase);
                    end
                end
                K_WALK:  startGreenAfter(mPhase);
                default: begin
                    if (e) begin
                        mKind  = K_HOLD;
                        mPhase = mEmg;
                        mLeft  = 0;
                    end else begin
                        startGreenAfter(mPhase);
                    end
                end
            endcase
        end
        mPending = newPending;
    endfunction

    function automatic expT modelOutputs();
        expT e;
        e.lights = '0;
        for (int p = 0; p < N; p++) begin
            if (p == mPhase) begin
                if (mKind == K_GO || mKind == K_HOLD) begin
                    e.lights[2*p +: 2] = 2'b10;
                end else if (mKind == K_AMBER || (mKind == K_PRE && mAmber)) begin
                    e.lights[2*p +: 2] = 2'b01;
                end
            end
        end
        e.phase   = PW'(mPhase);
        e.walk    = (mKind == K_WALK);
        e.pending = mPending;
        e.emgAct  = (mKind == K_PRE) || (mKind == K_HOLD);
        e.display = CNT_W'(mLeft);
        return e;
    endfunction

    task automatic checkField(input string name, input string tag, input int act, input int req);
        checkCount++;
        if (act != req) begin
            errorCount++;
            $display("[TB] FAIL %s %s cycle %0d: got %0d, expected %0d", tag, name, cycle, act, req);
        end
    endtask

    task automatic checkOutput(input expT e, input string tag);
        checkField("lights",        tag, int'(lights),       int'(e.lights));
        checkField("cur_phase",     tag, int'(curPhase),     int'(e.phase));
        checkField("ped_walk",      tag, int'(pedWalk),      int'(e.walk));
        checkField("ped_pending",   tag, int'(pedPending),   int'(e.pending));
        checkField("emg_active",    tag, int'(emgActive),    int'(e.emgAct));
        checkField("timer_display", tag, int'(timerDisplay), int'(e.display));
    endtask

    // One cycle of stimulus: drive at the falling edge, advance the model and
    // queue the outputs expected after the next rising edge.
    task automatic applyStimulus(input bit r, input bit p, input bit e, input int ph);
        @(negedge clk);
        cycle++;
        rst       = r;
        pedReq    = p;
        emergency = e;
        emgPhase  = PW'(ph);
        modelStep(r, p, e, ph);
        if (r) begin
            #1;
            checkOutput(modelOutputs(), "async_reset");
        end
        sbQ.push_back(modelOutputs());
    endtask

    // Monitor: compare the DUT against the oldest queued expectation once per cycle
    initial begin
        expT e;
        forever begin
            @(posedge clk);
            #1;
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput(e, "scoreboard");
            end
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence
    initial begin
        bit emgLevel;
        rst       = 1'b1;
        pedReq    = 1'b0;
        emergency = 1'b0;
        emgPhase  = '0;
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        checkOutput(modelOutputs(), "reset_state");

        $display("[TB] idle rotation with wrap-around");
        for (int i = 0; i < 40; i++) applyStimulus(0, 0, 0, 0);

        $display("[TB] pedestrian request served after all-red");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0);

        $display("[TB] emergency to phase 2 from green 0, then release");
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 2);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0);

        $display("[TB] emergency aborts a pedestrian walk");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 1);
        for (int i = 0; i < 25; i++) applyStimulus(0, 0, 0, 0);

        $display("[TB] emergency on the phase already green");
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0);

        $display("[TB] reset during hold and during yellow");
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 3);
        applyStimulus(1, 0, 1, 3);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0);

        $display("[TB] randomized traffic");
        emgLevel = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) emgLevel = !emgLevel;
            applyStimulus($urandom_range(0, 399) == 0,
                          $urandom_range(0, 9) == 0,
                          emgLevel,
                          int'($urandom_range(0, N - 1)));
        end

        repeat (3) @(posedge clk);
        #2;
        checkField("scoreboard_drain", "end", sbQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
